// File: rtl/sng_sched.sv
// sng_sched: frame scheduler for a bank of stochastic number generator lanes.
// Accepts one operand frame, pulses start to the lanes, waits the lane start
// latency, counts ones of the returned stream over a 16-cycle window, then
// pulses stop and presents the ones-count until it is consumed.
// Optional feature: define SNG_SCHED_PERF_EN to enable the completed-frame
// counter on o_frame_cnt (otherwise the port is tied to zero).
module sng_sched #(
    parameter int LANES     = 4,
    parameter int START_LAT = 2
) (
    input  logic               i_clk_sch,
    input  logic               i_rst_sch,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [4*LANES-1:0] i_in_data,
    output logic [4*LANES-1:0] o_x_bn,
    output logic               o_start_sng,
    output logic               o_stop_sng,
    input  logic               i_sn_bit,
    input  logic               i_abort,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [4:0]         o_out_count,
    output logic               o_busy,
    output logic [15:0]        o_frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Last value of the wait counter before RUN; WAIT spans START_LAT-1 cycles.
    localparam logic [2:0] WAIT_LAST = (START_LAT >= 2) ? 3'(START_LAT - 2) : 3'd0;

    state_t             r_state;
    logic [4*LANES-1:0] r_x_bn;
    logic [4:0]         r_acc;
    logic [3:0]         r_win;
    logic [2:0]         r_wait;
    logic               r_start;
    logic               r_stop;
    logic               r_valid;
    logic               r_busy;
    logic               w_accept;

    // Accumulator step: a 16-sample window never exceeds 16, so 5 bits cannot wrap.
    function automatic logic [4:0] acc_add(input logic [4:0] a, input logic b);
        return a + {4'd0, b};
    endfunction

    // A frame may be taken when idle, or when the current result is consumed this cycle.
    always_comb begin
        o_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_out_ready);
        w_accept   = i_in_valid && o_in_ready;
    end

    // Frame sequencing FSM with registered lane controls and result handshake.
    always_ff @(posedge i_clk_sch) begin
        if (i_rst_sch) begin
            r_state <= ST_IDLE;
            r_x_bn  <= '0;
            r_acc   <= '0;
            r_win   <= '0;
            r_wait  <= '0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            if (w_accept) begin
                r_x_bn  <= i_in_data;
                r_acc   <= '0;
                r_win   <= '0;
                r_wait  <= '0;
                r_start <= 1'b1;
                r_valid <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= ST_START;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (i_abort) begin
                            r_stop  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_acc   <= '0;
                            r_state <= ST_IDLE;
                        end else if (START_LAT == 1) begin
                            r_win   <= '0;
                            r_state <= ST_RUN;
                        end else begin
                            r_wait  <= '0;
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (i_abort) begin
                            r_stop  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_acc   <= '0;
                            r_state <= ST_IDLE;
                        end else if (r_wait == WAIT_LAST) begin
                            r_win   <= '0;
                            r_state <= ST_RUN;
                        end else begin
                            r_wait <= r_wait + 3'd1;
                        end
                    end
                    ST_RUN: begin
                        // Abort wins over the window end when both land together.
                        if (i_abort) begin
                            r_stop  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_acc   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_acc <= acc_add(r_acc, i_sn_bit);
                            if (r_win == 4'd15) begin
                                r_stop  <= 1'b1;
                                r_valid <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_win <= r_win + 4'd1;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Abort is ignored here; only the handshake leaves DONE.
                        if (i_out_ready) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_x_bn      = r_x_bn;
    assign o_start_sng = r_start;
    assign o_stop_sng  = r_stop;
    assign o_out_valid = r_valid;
    assign o_out_count = r_acc;
    assign o_busy      = r_busy;

`ifdef SNG_SCHED_PERF_EN
    logic [15:0] r_frame_cnt;
    logic        w_done_hs;

    assign w_done_hs = (r_state == ST_DONE) && i_out_ready;

    // Count results consumed; aborted frames never reach DONE so are not counted.
    always_ff @(posedge i_clk_sch) begin
        if (i_rst_sch) begin
            r_frame_cnt <= '0;
        end else if (w_done_hs) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`else
    assign o_frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sng_sched.sv
// Testbench for sng_sched (LANES=4, START_LAT=2): directed vector table,
// hand-written corner sequences and randomized traffic against a model that
// tracks each frame by its age in cycles since acceptance.
module tb_sng_sched;
    localparam int LANES    = 4;
    localparam int SL       = 2;
    localparam int DONE_AGE = SL + 17;

    logic        clk = 1'b0;
    logic        i_rst_sch;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_in_data;
    logic [15:0] o_x_bn;
    logic        o_start_sng;
    logic        o_stop_sng;
    logic        i_sn_bit;
    logic        i_abort;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [4:0]  o_out_count;
    logic        o_busy;
    logic [15:0] o_frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: age = cycles since accept (-1 when no frame held).
    int          age      = -1;
    bit          m_stop   = 1'b0;
    logic [15:0] m_x      = 16'd0;
    int          m_ones   = 0;
    int          m_frames = 0;
    bit          rst_flag = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [15:0] pattern;
        int          abort_run;
        int          hold;
        int          exp_lat;
        int          exp_count;
    } vec_t;
    vec_t vecs[6];

    sng_sched #(.LANES(LANES), .START_LAT(SL)) dut (
        .i_clk_sch  (clk),
        .i_rst_sch  (i_rst_sch),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_data  (i_in_data),
        .o_x_bn     (o_x_bn),
        .o_start_sng(o_start_sng),
        .o_stop_sng (o_stop_sng),
        .i_sn_bit   (i_sn_bit),
        .i_abort    (i_abort),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_out_count(o_out_count),
        .o_busy     (o_busy),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic bit model_ready();
        return (age < 0) || ((age >= DONE_AGE) && i_out_ready);
    endfunction

    function automatic logic [15:0] exp_fc();
`ifdef SNG_SCHED_PERF_EN
        return 16'(m_frames);
`else
        return 16'd0;
`endif
    endfunction

    function automatic void model_accept();
        age    = 1;
        m_x    = i_in_data;
        m_ones = 0;
    endfunction

    function automatic void model_update();
        if (i_rst_sch) begin
            age = -1; m_stop = 1'b0; m_x = 16'd0; m_ones = 0; m_frames = 0; rst_flag = 1'b1;
        end else begin
            rst_flag = 1'b0;
            m_stop   = 1'b0;
            if (age < 0) begin
                if (i_in_valid) model_accept();
            end else if (age < DONE_AGE) begin
                if (i_abort) begin
                    age = -1; m_stop = 1'b1;
                end else begin
                    if (age >= SL + 1) m_ones += int'(i_sn_bit);
                    age++;
                    if (age == DONE_AGE) m_stop = 1'b1;
                end
            end else if (i_out_ready) begin
                m_frames++;
                if (i_in_valid) model_accept();
                else age = -1;
            end
        end
    endfunction

    task automatic tick();
        #1;
        check("in_ready", 32'(o_in_ready), 32'(model_ready()));
        model_update();
        @(posedge clk);
        #1;
        check("start", 32'(o_start_sng), 32'(age == 1));
        check("stop", 32'(o_stop_sng), 32'(m_stop));
        check("valid", 32'(o_out_valid), 32'(age >= DONE_AGE));
        check("busy", 32'(o_busy), 32'(age >= 1));
        check("x_bn", 32'(o_x_bn), 32'(m_x));
        check("frame_cnt", 32'(o_frame_cnt), 32'(exp_fc()));
        check("start_stop_excl", 32'(o_start_sng & o_stop_sng), 32'd0);
        if (age >= DONE_AGE) check("count", 32'(o_out_count), 32'(m_ones));
        else if (rst_flag) check("count_rst", 32'(o_out_count), 32'd0);
    endtask

    task automatic drain();
        i_in_valid = 1'b0; i_abort = 1'b0; i_out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (!o_busy && !o_out_valid) break;
            tick();
        end
        check("drain_idle", 32'(o_busy), 32'd0);
        i_out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          first_valid;
        logic [15:0] pat;
        first_valid = 0;
        pat         = v.pattern;
        check($sformatf("vec%0d_ready", idx), 32'(o_in_ready), 32'd1);
        i_in_valid = 1'b1; i_in_data = v.data; i_out_ready = 1'b0; i_abort = 1'b0; i_sn_bit = 1'b0;
        tick();
        i_in_valid = 1'b0;
        check($sformatf("vec%0d_start_T1", idx), 32'(o_start_sng), 32'd1);
        for (int d = 1; d <= SL + 18; d++) begin
            if (o_out_valid) begin
                first_valid = d;
                break;
            end
            if (d >= SL + 1 && d <= SL + 16) begin
                i_sn_bit = pat[15];
                pat      = pat << 1;
            end else begin
                i_sn_bit = 1'b0;
            end
            i_abort = (v.abort_run != 0) && (d == SL + v.abort_run);
            tick();
            i_abort = 1'b0;
            if (v.abort_run != 0 && d == SL + v.abort_run)
                check($sformatf("vec%0d_abort_stop", idx), 32'(o_stop_sng), 32'd1);
        end
        check($sformatf("vec%0d_lat", idx), 32'(first_valid), 32'(v.exp_lat));
        if (first_valid != 0) begin
            check($sformatf("vec%0d_count", idx), 32'(o_out_count), 32'(v.exp_count));
            check($sformatf("vec%0d_x_bn", idx), 32'(o_x_bn), 32'(v.data));
            check($sformatf("vec%0d_stop", idx), 32'(o_stop_sng), 32'd1);
            for (int h = 0; h < v.hold; h++) begin
                i_out_ready = 1'b0;
                tick();
                check($sformatf("vec%0d_hold_count", idx), 32'(o_out_count), 32'(v.exp_count));
                check($sformatf("vec%0d_hold_ready", idx), 32'(o_in_ready), 32'd0);
            end
            i_out_ready = 1'b1;
            tick();
            i_out_ready = 1'b0;
        end
        check($sformatf("vec%0d_end_idle", idx), 32'(o_busy), 32'd0);
    endtask

    task automatic do_reset();
        i_rst_sch = 1'b1;
        tick();
        i_rst_sch = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hF8A3, 16'hFFFF, 0, 0, 19, 16};
        vecs[1] = '{16'h1234, 16'hAAAA, 0, 5, 19, 8};
        vecs[2] = '{16'h0000, 16'h0000, 0, 1, 19, 0};
        vecs[3] = '{16'hABCD, 16'h0001, 0, 0, 19, 1};
        vecs[4] = '{16'h5A5A, 16'h8421, 0, 2, 19, 4};
        vecs[5] = '{16'h0F0F, 16'hFFFF, 6, 0, 0, 0};

        i_rst_sch = 1'b1; i_in_valid = 1'b0; i_in_data = 16'd0; i_sn_bit = 1'b0;
        i_abort = 1'b0; i_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        check("rst_x_bn", 32'(o_x_bn), 32'd0);
        check("rst_valid", 32'(o_out_valid), 32'd0);
        check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        i_rst_sch = 1'b0;
        #1;
        check("ready_after_rst", 32'(o_in_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Three completed frames plus one aborted frame from a clean reset
        do_reset();
        run_vec(vecs[0], 10);
        run_vec(vecs[2], 11);
        run_vec(vecs[5], 12);
        run_vec(vecs[3], 13);
`ifdef SNG_SCHED_PERF_EN
        check("frame_cnt_3", 32'(o_frame_cnt), 32'd3);
`else
        check("frame_cnt_0", 32'(o_frame_cnt), 32'd0);
`endif

        // Result consumed and new frame accepted in the same cycle
        i_in_valid = 1'b1; i_in_data = 16'h1111; i_out_ready = 1'b0; tick();
        i_in_valid = 1'b0;
        for (int k = 0; k < DONE_AGE - 1; k++) begin
            i_sn_bit = 1'($urandom_range(0, 1));
            tick();
        end
        check("b2b_valid", 32'(o_out_valid), 32'd1);
        i_in_valid = 1'b1; i_in_data = 16'h2222; i_out_ready = 1'b1;
        tick();
        check("b2b_start", 32'(o_start_sng), 32'd1);
        check("b2b_valid_drop", 32'(o_out_valid), 32'd0);
        check("b2b_x_bn", 32'(o_x_bn), 32'h2222);
        drain();

        // Reset during WAIT
        i_in_valid = 1'b1; i_in_data = 16'h7777; tick();
        i_in_valid = 1'b0; tick();
        check("wait_busy", 32'(o_busy), 32'd1);
        i_rst_sch = 1'b1; tick();
        check("rstw_x_bn", 32'(o_x_bn), 32'd0);
        check("rstw_start", 32'(o_start_sng), 32'd0);
        check("rstw_stop", 32'(o_stop_sng), 32'd0);
        check("rstw_valid", 32'(o_out_valid), 32'd0);
        check("rstw_count", 32'(o_out_count), 32'd0);
        check("rstw_busy", 32'(o_busy), 32'd0);
        check("rstw_fc", 32'(o_frame_cnt), 32'd0);
        i_rst_sch = 1'b0;
        #1;
        check("rstw_ready", 32'(o_in_ready), 32'd1);

        // Abort in START
        i_in_valid = 1'b1; i_in_data = 16'h3333; tick();
        i_in_valid = 1'b0; i_abort = 1'b1; tick();
        i_abort = 1'b0;
        check("abort_start_stop", 32'(o_stop_sng), 32'd1);
        check("abort_start_busy", 32'(o_busy), 32'd0);
        tick();
        check("abort_start_stop_once", 32'(o_stop_sng), 32'd0);

        // Abort coinciding with the last window cycle
        i_in_valid = 1'b1; i_in_data = 16'h4444; i_sn_bit = 1'b1; tick();
        i_in_valid = 1'b0;
        for (int k = 0; k < SL + 15; k++) tick();
        i_abort = 1'b1; tick();
        i_abort = 1'b0;
        check("abort_end_valid", 32'(o_out_valid), 32'd0);
        check("abort_end_stop", 32'(o_stop_sng), 32'd1);
        tick();
        check("abort_end_novalid", 32'(o_out_valid), 32'd0);

        // Abort ignored in DONE, then in IDLE
        i_in_valid = 1'b1; i_in_data = 16'h5555; tick();
        i_in_valid = 1'b0;
        for (int k = 0; k < DONE_AGE - 1; k++) tick();
        i_abort = 1'b1; i_out_ready = 1'b0; tick();
        check("abort_done_valid", 32'(o_out_valid), 32'd1);
        check("abort_done_stop", 32'(o_stop_sng), 32'd0);
        i_abort = 1'b0; i_out_ready = 1'b1; tick();
        i_out_ready = 1'b0;
        i_abort = 1'b1; tick();
        check("abort_idle_stop", 32'(o_stop_sng), 32'd0);
        i_in_valid = 1'b1; i_in_data = 16'h6666; tick();
        check("abort_idle_accept", 32'(o_start_sng), 32'd1);
        i_abort = 1'b0;

        // Offer while busy is ignored
        i_in_valid = 1'b1; i_in_data = 16'hBEEF; tick(); tick();
        check("busy_ignore_x", 32'(o_x_bn), 32'h6666);
        drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            i_rst_sch   = ($urandom_range(0, 599) == 0);
            i_in_valid  = 1'($urandom_range(0, 1));
            i_in_data   = 16'($urandom);
            i_sn_bit    = 1'($urandom_range(0, 1));
            i_abort     = ($urandom_range(0, 59) == 0);
            i_out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
